// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: modulus MAX_VAL+1, wrap or saturate, parallel load with clamp.
// Latency 1 cycle from inputs to count/ovf/unf; tc is combinational; no backpressure, the counter always accepts.
module updown_counter_param #(
    parameter int WIDTH     = 3,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
    localparam bit               SAT_C = (SATURATE != 0);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    assign at_max  = (count == MAX_C);
    assign at_zero = (count == '0);
    assign tc      = en & ((up_down & at_max) | (~up_down & at_zero));

    // Limits are handled explicitly so a non-power-of-two modulus never relies on natural rollover.
    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (load) begin
            count_nxt = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en) begin
            if (up_down) begin
                if (at_max) begin
                    count_nxt = SAT_C ? MAX_C : '0;
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    count_nxt = SAT_C ? '0 : MAX_C;
                    unf_nxt   = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= RST_C;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: three counter configurations sharing one stimulus bus, each task checks the relevant instance.
module tb_updown_counter_param;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_down;
    logic       load;
    logic [3:0] load_val;

    logic [2:0] cnt0;
    logic       tc0, ovf0, unf0;
    logic [2:0] cnt1;
    logic       tc1, ovf1, unf1;
    logic [3:0] cnt2;
    logic       tc2, ovf2, unf2;

    int checks   = 0;
    int failures = 0;

    // mod-8 wrap
    updown_counter_param #(.WIDTH(3), .MAX_VAL(7), .SATURATE(0), .RESET_VAL(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val[2:0]), .count(cnt0), .tc(tc0), .ovf(ovf0), .unf(unf0)
    );

    // mod-6 wrap
    updown_counter_param #(.WIDTH(3), .MAX_VAL(5), .SATURATE(0), .RESET_VAL(0)) u1 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val[2:0]), .count(cnt1), .tc(tc1), .ovf(ovf1), .unf(unf1)
    );

    // 0..9 saturating, non-zero reset value
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RESET_VAL(2)) u2 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .count(cnt2), .tc(tc2), .ovf(ovf2), .unf(unf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; up_down = 1'b1; load = 1'b0; load_val = 4'd0;
        tick();
        tick();
        checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
        checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin failures++; $display("FAIL reset_flags0 got ovf=%b unf=%b exp 0 0", ovf0, unf0); end
        checks++; if (tc0 !== 1'b0) begin failures++; $display("FAIL reset_tc0 got=%b exp=0", tc0); end
        checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
        checks++; if (cnt2 !== 4'd2) begin failures++; $display("FAIL reset_cnt2 got=%0d exp=2", cnt2); end
        checks++; if (ovf2 !== 1'b0 || unf2 !== 1'b0) begin failures++; $display("FAIL reset_flags2 got ovf=%b unf=%b exp 0 0", ovf2, unf2); end
    endtask

    task automatic test_wrap_up();
        int exp_cnt [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        int exp_ovf [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        int exp_tc  [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        reset = 1'b1; en = 1'b1; up_down = 1'b1; load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++; if (cnt0 !== 3'(exp_cnt[i])) begin failures++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, cnt0, exp_cnt[i]); end
            checks++; if (ovf0 !== 1'(exp_ovf[i]) || unf0 !== 1'b0) begin failures++; $display("FAIL wrap_flags[%0d] got ovf=%b unf=%b exp ovf=%0d unf=0", i, ovf0, unf0, exp_ovf[i]); end
            checks++; if (tc0 !== 1'(exp_tc[i])) begin failures++; $display("FAIL wrap_tc[%0d] got=%b exp=%0d", i, tc0, exp_tc[i]); end
        end
    endtask

    task automatic test_mod6();
        int dn_cnt [3] = '{0, 5, 4};
        int dn_unf [3] = '{0, 1, 0};
        int dn_tc  [3] = '{1, 0, 0};
        int up_cnt [3] = '{5, 0, 1};
        int up_ovf [3] = '{0, 1, 0};
        int up_tc  [3] = '{1, 0, 0};
        reset = 1'b1; load = 1'b1; load_val = 4'd1; en = 1'b0; up_down = 1'b0;
        tick();
        checks++; if (cnt1 !== 3'd1) begin failures++; $display("FAIL mod6_load got=%0d exp=1", cnt1); end
        load = 1'b0; en = 1'b1; up_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cnt1 !== 3'(dn_cnt[i])) begin failures++; $display("FAIL mod6_dn_cnt[%0d] got=%0d exp=%0d", i, cnt1, dn_cnt[i]); end
            checks++; if (unf1 !== 1'(dn_unf[i]) || ovf1 !== 1'b0) begin failures++; $display("FAIL mod6_dn_flags[%0d] got unf=%b ovf=%b exp unf=%0d ovf=0", i, unf1, ovf1, dn_unf[i]); end
            checks++; if (tc1 !== 1'(dn_tc[i])) begin failures++; $display("FAIL mod6_dn_tc[%0d] got=%b exp=%0d", i, tc1, dn_tc[i]); end
        end
        up_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cnt1 !== 3'(up_cnt[i])) begin failures++; $display("FAIL mod6_up_cnt[%0d] got=%0d exp=%0d", i, cnt1, up_cnt[i]); end
            checks++; if (ovf1 !== 1'(up_ovf[i]) || unf1 !== 1'b0) begin failures++; $display("FAIL mod6_up_flags[%0d] got ovf=%b unf=%b exp ovf=%0d unf=0", i, ovf1, unf1, up_ovf[i]); end
            checks++; if (tc1 !== 1'(up_tc[i])) begin failures++; $display("FAIL mod6_up_tc[%0d] got=%b exp=%0d", i, tc1, up_tc[i]); end
        end
    endtask

    task automatic test_saturate();
        int up_ovf [4] = '{0, 1, 1, 1};
        reset = 1'b1; load = 1'b1; load_val = 4'd8; en = 1'b0; up_down = 1'b1;
        tick();
        checks++; if (cnt2 !== 4'd8) begin failures++; $display("FAIL sat_load got=%0d exp=8", cnt2); end
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (cnt2 !== 4'd9) begin failures++; $display("FAIL sat_up_cnt[%0d] got=%0d exp=9", i, cnt2); end
            checks++; if (ovf2 !== 1'(up_ovf[i]) || unf2 !== 1'b0) begin failures++; $display("FAIL sat_up_flags[%0d] got ovf=%b unf=%b exp ovf=%0d unf=0", i, ovf2, unf2, up_ovf[i]); end
            checks++; if (tc2 !== 1'b1) begin failures++; $display("FAIL sat_up_tc[%0d] got=%b exp=1", i, tc2); end
        end
        load = 1'b1; load_val = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_down = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (cnt2 !== 4'd0) begin failures++; $display("FAIL sat_dn_cnt[%0d] got=%0d exp=0", i, cnt2); end
            checks++; if (unf2 !== 1'b1 || ovf2 !== 1'b0) begin failures++; $display("FAIL sat_dn_flags[%0d] got unf=%b ovf=%b exp unf=1 ovf=0", i, unf2, ovf2); end
            checks++; if (tc2 !== 1'b1) begin failures++; $display("FAIL sat_dn_tc[%0d] got=%b exp=1", i, tc2); end
        end
    endtask

    task automatic test_load_priority();
        reset = 1'b1; load = 1'b1; load_val = 4'd9; en = 1'b1; up_down = 1'b1;
        tick();
        // At MAX_VAL with en=1 up: load must win, so no ovf and the clamp applies.
        load_val = 4'd13;
        tick();
        checks++; if (cnt2 !== 4'd9) begin failures++; $display("FAIL load_clamp_cnt got=%0d exp=9", cnt2); end
        checks++; if (ovf2 !== 1'b0 || unf2 !== 1'b0) begin failures++; $display("FAIL load_clamp_flags got ovf=%b unf=%b exp 0 0", ovf2, unf2); end
        checks++; if (tc2 !== 1'b1) begin failures++; $display("FAIL load_tc_indep got=%b exp=1", tc2); end
        reset = 1'b0;
        tick();
        checks++; if (cnt2 !== 4'd2) begin failures++; $display("FAIL reset_over_load got=%0d exp=2", cnt2); end
        checks++; if (ovf2 !== 1'b0 || unf2 !== 1'b0) begin failures++; $display("FAIL reset_over_load_flags got ovf=%b unf=%b exp 0 0", ovf2, unf2); end
        reset = 1'b1; load = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b0; up_down = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        checks++; if (cnt0 !== 3'd4) begin failures++; $display("FAIL mid_pre_cnt got=%0d exp=4", cnt0); end
        reset = 1'b0;
        tick();
        checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL mid_reset_cnt got=%0d exp=0", cnt0); end
        checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin failures++; $display("FAIL mid_reset_flags got ovf=%b unf=%b exp 0 0", ovf0, unf0); end
        reset = 1'b1;
        tick();
        checks++; if (cnt0 !== 3'd1) begin failures++; $display("FAIL mid_resume_cnt got=%0d exp=1", cnt0); end
        checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin failures++; $display("FAIL mid_resume_flags got ovf=%b unf=%b exp 0 0", ovf0, unf0); end
    endtask

    task automatic test_hold_toggle();
        int exp_cnt [4] = '{4, 3, 4, 3};
        reset = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b0; up_down = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cnt0 !== 3'd3) begin failures++; $display("FAIL hold_cnt[%0d] got=%0d exp=3", i, cnt0); end
            checks++; if (tc0 !== 1'b0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin failures++; $display("FAIL hold_tc_flags[%0d] got tc=%b ovf=%b unf=%b exp 0 0 0", i, tc0, ovf0, unf0); end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_down = (i % 2 == 0);
            tick();
            checks++; if (cnt0 !== 3'(exp_cnt[i])) begin failures++; $display("FAIL toggle_cnt[%0d] got=%0d exp=%0d", i, cnt0, exp_cnt[i]); end
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up_down = 1'b0; load = 1'b0; load_val = 4'd0;
        test_reset();
        test_wrap_up();
        test_mod6();
        test_saturate();
        test_load_priority();
        test_reset_mid();
        test_hold_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised synchronous up/down counter. It extends the 3-bit asynchronous up/down counter to generic width and programmable modulus. It adds a count enable, parallel load, a selectable wrap or saturate mode, a terminal-count output and overflow/underflow event flags. It is the general-purpose counter for timers, address generators and event counting throughout the design.

Parameters:
WIDTH, 3, counter width in bits (>= 1).
MAX_VAL, 2**WIDTH-1, highest count value. The count range is 0..MAX_VAL. Legal range is 1 <= MAX_VAL <= 2**WIDTH-1.
SATURATE, 0, 0 = wrap at the range limits, 1 = hold at the range limits.
RESET_VAL, 0, count value after reset. Must be <= MAX_VAL.

Ports:
clk  input  1  global clock; all state updates on the rising edge.
reset  input  1  synchronous reset, active-low: reset==0 at a rising clk edge resets the block.
en  input  1  count enable; when 0 the count holds.
up_down  input  1  direction: 1 = up, 0 = down.
load  input  1  parallel-load strobe.
load_val  input  WIDTH  value to load.
count  output  WIDTH  current count (registered).
tc  output  1  terminal count (combinational): the next enabled step crosses a limit.
ovf  output  1  one-cycle pulse: an up-step was attempted at MAX_VAL (registered).
unf  output  1  one-cycle pulse: a down-step was attempted at 0 (registered).

Behaviour:
- Update priority at each rising clk edge: reset > load > en > hold.
- Reset (reset==0): count=RESET_VAL, ovf=0, unf=0. Reset takes effect regardless of load, en or up_down. Reset asserted mid-count aborts the count; no flag is raised.
- Load (load==1, reset==1): count=load_val if load_val <= MAX_VAL, else count=MAX_VAL (clamp). ovf=0, unf=0. en is ignored in that cycle.
- Count up (en==1, up_down==1, load==0):
  - If count < MAX_VAL: count=count+1, ovf=0.
  - If count == MAX_VAL: count=0 (SATURATE=0) or count=MAX_VAL (SATURATE=1); ovf=1.
- Count down (en==1, up_down==0, load==0):
  - If count > 0: count=count-1, unf=0.
  - If count == 0: count=MAX_VAL (SATURATE=0) or count=0 (SATURATE=1); unf=1.
- Hold (en==0, load==0): count unchanged, ovf=0, unf=0.
- ovf/unf timing: registered, asserted for exactly the one cycle following the offending edge, i.e. aligned with the new count value. In saturate mode, holding en=1 at a limit produces ovf (or unf) on every cycle. ovf and unf are never both 1.
- tc = en & ((up_down & count==MAX_VAL) | (~up_down & count==0)). It is purely combinational and does not depend on load.
- Direction change: takes effect on the next enabled edge. There is no pipeline, so count latency is 1 cycle from input to count.
- Arithmetic: all compares are unsigned at WIDTH bits. The wrap for a non-power-of-two MAX_VAL is explicit; the design must not rely on natural 2**WIDTH rollover.
- All outputs are defined (no X) from the first edge with reset==0 onward.

Test Plan:
- WIDTH=3, MAX_VAL=7, SATURATE=0: reset=0 for 2 cycles, then en=1, up_down=1 for 9 cycles. Required: count 0,1,...,7,0,1; ovf=1 only in the cycle count shows 0 after 7; tc=1 while count==7.
- WIDTH=3, MAX_VAL=5, SATURATE=0: from count=1, down for 3 cycles. Required: count 0,5,4; unf=1 aligned with 5. Then up from 4 for 3 cycles. Required: count 5,0,1; ovf aligned with 0.
- WIDTH=4, MAX_VAL=9, SATURATE=1: load_val=8, then up for 4 cycles. Required: count 9,9,9,9; ovf=1 on the last 3 cycles. Then down from 0 for 2 cycles. Required: count stays 0; unf=1 both cycles.
- Load clamp and priority: WIDTH=4, MAX_VAL=9, load=1, load_val=13, en=1. Required: count=9, ovf=0. Then load=1 together with reset=0. Required: count=RESET_VAL.
- Reset mid-operation: counting up at count=4, drive reset=0 for one edge with en=1. Required: count=RESET_VAL, ovf=unf=0; counting resumes from RESET_VAL on the next edge.
- Hold and direction toggle: en=0 for 3 cycles at count=3. Required: count stays 3, tc=0, no flags. Then alternate up_down each cycle with en=1. Required: count 4,3,4,3.
